// File: rtl/vga_timing_gen.sv
// VGA timing generator with parameterised geometry, run-time 1x/2x/4x source
// upscaling and sync/colour outputs aligned to a fixed-latency pixel source.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIX_W     = 16,
    parameter int PIPE_LAT  = 2,
    parameter int CNT_W     = 10
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic [1:0]       scale_mode,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    input  logic [PIX_W-1:0] pix_data,
    output logic             hsync,
    output logic             vsync,
    output logic             rgb_valid,
    output logic [PIX_W-1:0] rgb,
    output logic             frame_start,
    output logic             line_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_DISP_C   = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_DISP_C   = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_FINAL   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_FINAL   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONES   = {CNT_W{1'b1}};
    localparam logic [PIX_W-1:0] PIX_ZERO   = {PIX_W{1'b0}};

    // Flag vector layout carried through the latency-matching delay line.
    localparam int FLAG_W = 5;
    localparam int F_ACT  = 4;
    localparam int F_HS   = 3;
    localparam int F_VS   = 2;
    localparam int F_FS   = 1;
    localparam int F_LS   = 0;
    localparam logic [FLAG_W-1:0] FLAGS_IDLE = 5'd0;

    logic [CNT_W-1:0]  h_cnt_r;
    logic [CNT_W-1:0]  v_cnt_r;
    logic [1:0]        mode_r;
    logic              h_last_s;
    logic              v_last_s;
    logic              active_s;
    logic              hs_cond_s;
    logic              vs_cond_s;
    logic              fs_flag_s;
    logic              ls_flag_s;
    logic [1:0]        shift_s;
    logic [CNT_W-1:0]  pix_x_s;
    logic [CNT_W-1:0]  pix_y_s;
    logic [FLAG_W-1:0] flags_s;
    logic [FLAG_W-1:0] dly_flags_s;

    logic              hsync_r;
    logic              vsync_r;
    logic              rgb_valid_r;
    logic [PIX_W-1:0]  rgb_r;
    logic              frame_start_r;
    logic              line_start_r;

    assign h_last_s = (h_cnt_r == H_LAST);
    assign v_last_s = (v_cnt_r == V_LAST);

    // Raster counters; the scale mode only changes on the last cycle of a frame.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h_cnt_r <= CNT_ZERO;
            v_cnt_r <= CNT_ZERO;
            mode_r  <= 2'd0;
        end else begin
            if (h_last_s) begin
                h_cnt_r <= CNT_ZERO;
                if (v_last_s) begin
                    v_cnt_r <= CNT_ZERO;
                end else begin
                    v_cnt_r <= v_cnt_r + CNT_ONE;
                end
            end else begin
                h_cnt_r <= h_cnt_r + CNT_ONE;
            end
            if (h_last_s && v_last_s) begin
                mode_r <= scale_mode;
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    // Stage-0 decode: active area, sync windows, start markers, scaled coordinates.
    always_comb begin
        active_s  = 1'b0;
        hs_cond_s = 1'b0;
        vs_cond_s = 1'b0;
        fs_flag_s = 1'b0;
        ls_flag_s = 1'b0;
        shift_s   = 2'd0;
        pix_x_s   = CNT_ONES;
        pix_y_s   = CNT_ONES;

        active_s  = (h_cnt_r < H_DISP_C) && (v_cnt_r < V_DISP_C);
        hs_cond_s = (h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_FINAL);
        vs_cond_s = (v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_FINAL);
        fs_flag_s = (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);
        ls_flag_s = (h_cnt_r == CNT_ZERO) && (v_cnt_r < V_DISP_C);

        case (mode_r)
            2'd1:    shift_s = 2'd1;
            2'd2:    shift_s = 2'd2;
            default: shift_s = 2'd0;
        endcase

        if (active_s) begin
            pix_x_s = h_cnt_r >> shift_s;
            pix_y_s = v_cnt_r >> shift_s;
        end else begin
            pix_x_s = CNT_ONES;
            pix_y_s = CNT_ONES;
        end
    end

    assign pix_req = active_s;
    assign pix_x   = pix_x_s;
    assign pix_y   = pix_y_s;

    always_comb begin
        flags_s        = FLAGS_IDLE;
        flags_s[F_ACT] = active_s;
        flags_s[F_HS]  = hs_cond_s;
        flags_s[F_VS]  = vs_cond_s;
        flags_s[F_FS]  = fs_flag_s;
        flags_s[F_LS]  = ls_flag_s;
    end

    generate
        if (PIPE_LAT == 0) begin : g_no_delay
            assign dly_flags_s = flags_s;
        end else begin : g_delay
            logic [FLAG_W-1:0] dly_r [PIPE_LAT];

            // Shift register matching the pixel source read latency.
            always_ff @(posedge vga_clk) begin
                if (sys_rst) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        dly_r[i] <= FLAGS_IDLE;
                    end
                end else begin
                    dly_r[0] <= flags_s;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end
            end

            assign dly_flags_s = dly_r[PIPE_LAT-1];
        end
    endgenerate

    // Output register: delayed flags are captured together with the fetched colour.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            hsync_r       <= ~HSYNC_POL;
            vsync_r       <= ~VSYNC_POL;
            rgb_valid_r   <= 1'b0;
            rgb_r         <= PIX_ZERO;
            frame_start_r <= 1'b0;
            line_start_r  <= 1'b0;
        end else begin
            hsync_r       <= dly_flags_s[F_HS] ? HSYNC_POL : ~HSYNC_POL;
            vsync_r       <= dly_flags_s[F_VS] ? VSYNC_POL : ~VSYNC_POL;
            rgb_valid_r   <= dly_flags_s[F_ACT];
            rgb_r         <= dly_flags_s[F_ACT] ? pix_data : PIX_ZERO;
            frame_start_r <= dly_flags_s[F_FS];
            line_start_r  <= dly_flags_s[F_LS];
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign rgb_valid   = rgb_valid_r;
    assign rgb         = rgb_r;
    assign frame_start = frame_start_r;
    assign line_start  = line_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster so whole frames fit in
// a short run; a second instance covers active-high sync and zero latency.
module tb_vga_timing_gen;

    localparam int HD = 16, HF = 2, HS = 4, HB = 2, HT = HD + HF + HS + HB;
    localparam int VD = 12, VF = 1, VS = 2, VB = 1, VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int LAT = 2;

    localparam int HD2 = 20, HF2 = 2, HS2 = 6, HB2 = 4, HT2 = HD2 + HF2 + HS2 + HB2;
    localparam int VD2 = 4, VF2 = 1, VS2 = 1, VB2 = 1, VT2 = VD2 + VF2 + VS2 + VB2;

    typedef struct packed {
        logic        act;
        logic        hs_lo;
        logic        vs_lo;
        logic        fs;
        logic        ls;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [15:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  scale_mode;
    logic        pix_req;
    logic [9:0]  pix_x, pix_y;
    logic [15:0] pix_data;
    logic        hsync, vsync, rgb_valid, frame_start, line_start;
    logic [15:0] rgb;

    logic [1:0]  scale_mode2;
    logic        pix_req2;
    logic [9:0]  pix_x2, pix_y2;
    logic [15:0] pix_data2;
    logic        hsync2, vsync2, rgb_valid2, frame_start2, line_start2;
    logic [15:0] rgb2;

    logic [15:0] src_q [LAT];

    int n_checks = 0;
    int n_errors = 0;

    exp_t hist [4];
    int sp, cur_mode, next_mode, k;
    int sb_err, px_err, t_valid, t_ls, t_fs, t_hlo, t_vlo;
    int first_hlo, first_vlo, first_fs, tgt_x, cnt_x, cnt_blank, ymax;

    always #5 clk = ~clk;

    assign scale_mode2 = 2'd0;
    assign pix_data2   = 16'h0000;

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .PIX_W(16), .PIPE_LAT(LAT), .CNT_W(10)
    ) dut (
        .vga_clk(clk), .sys_rst(sys_rst), .scale_mode(scale_mode),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .hsync(hsync), .vsync(vsync), .rgb_valid(rgb_valid), .rgb(rgb),
        .frame_start(frame_start), .line_start(line_start)
    );

    vga_timing_gen #(
        .H_DISPLAY(HD2), .H_FRONT(HF2), .H_SYNC(HS2), .H_BACK(HB2),
        .V_DISPLAY(VD2), .V_FRONT(VF2), .V_SYNC(VS2), .V_BACK(VB2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .PIX_W(16), .PIPE_LAT(0), .CNT_W(10)
    ) dut2 (
        .vga_clk(clk), .sys_rst(sys_rst), .scale_mode(scale_mode2),
        .pix_req(pix_req2), .pix_x(pix_x2), .pix_y(pix_y2), .pix_data(pix_data2),
        .hsync(hsync2), .vsync(vsync2), .rgb_valid(rgb_valid2), .rgb(rgb2),
        .frame_start(frame_start2), .line_start(line_start2)
    );

    // Pixel source: returns {y,x} of the request LAT cycles later.
    always @(posedge clk) begin
        src_q[0] <= {pix_y[7:0], pix_x[7:0]};
        for (int i = 1; i < LAT; i++) src_q[i] <= src_q[i-1];
    end
    assign pix_data = src_q[LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t stage_exp(input int p, input int mode);
        exp_t e;
        int h, v, sh;
        h  = p % HT;
        v  = p / HT;
        sh = (mode == 1) ? 1 : ((mode == 2) ? 2 : 0);
        e.act   = (h < HD) && (v < VD);
        e.hs_lo = (h >= HD + HF) && (h < HD + HF + HS);
        e.vs_lo = (v >= VD + VF) && (v < VD + VF + VS);
        e.fs    = (p == 0);
        e.ls    = (h == 0) && (v < VD);
        e.px    = e.act ? 10'(h >> sh) : 10'h3FF;
        e.py    = e.act ? 10'(v >> sh) : 10'h3FF;
        e.rgb   = e.act ? {8'(v >> sh), 8'(h >> sh)} : 16'h0000;
        return e;
    endfunction

    task automatic step();
        exp_t e;
        if (sp == FRAME - 1) next_mode = int'(scale_mode);
        @(negedge clk);
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        if (sp == FRAME - 1) begin
            sp = 0;
            cur_mode = next_mode;
        end else begin
            sp = sp + 1;
        end
        hist[0] = stage_exp(sp, cur_mode);
        if (pix_req !== hist[0].act || pix_x !== hist[0].px || pix_y !== hist[0].py) px_err++;
        e = hist[3];
        if (rgb_valid !== e.act || hsync !== ~e.hs_lo || vsync !== ~e.vs_lo ||
            frame_start !== e.fs || line_start !== e.ls || rgb !== e.rgb) sb_err++;
        if (rgb_valid === 1'b1) t_valid++;
        if (line_start === 1'b1) t_ls++;
        if (frame_start === 1'b1) begin
            t_fs++;
            if (first_fs < 0) first_fs = k;
        end
        if (hsync === 1'b0) begin
            t_hlo++;
            if (first_hlo < 0) first_hlo = k;
        end
        if (vsync === 1'b0) begin
            t_vlo++;
            if (first_vlo < 0) first_vlo = k;
        end
        if (pix_req === 1'b1 && int'(pix_x) == tgt_x) cnt_x++;
        if (pix_x === 10'h3FF) cnt_blank++;
        if (pix_req === 1'b1 && int'(pix_y) > ymax) ymax = int'(pix_y);
        k++;
    endtask

    // One output frame, starting on the cycle that shows frame_start.
    task automatic run_frame(input string tag, input int sw_k, input logic [1:0] sw_mode,
                             input int x_val, input int x_cnt, input int y_max);
        k = 0; sb_err = 0; px_err = 0; t_valid = 0; t_ls = 0; t_fs = 0;
        t_hlo = 0; t_vlo = 0; first_hlo = -1; first_vlo = -1; first_fs = -1;
        tgt_x = x_val; cnt_x = 0; cnt_blank = 0; ymax = 0;
        repeat (FRAME) begin
            step();
            if (k == sw_k) scale_mode = sw_mode;
        end
        check_eq({tag, "_scoreboard"}, sb_err, 0);
        check_eq({tag, "_pix_coords"}, px_err, 0);
        check_eq({tag, "_fs_offset"}, first_fs, 0);
        check_eq({tag, "_fs_count"}, t_fs, 1);
        check_eq({tag, "_valid_count"}, t_valid, 192);
        check_eq({tag, "_ls_count"}, t_ls, 12);
        check_eq({tag, "_hsync_low"}, t_hlo, 64);
        check_eq({tag, "_hsync_first"}, first_hlo, 18);
        check_eq({tag, "_vsync_low"}, t_vlo, 48);
        check_eq({tag, "_vsync_first"}, first_vlo, 312);
        check_eq({tag, "_x_hold"}, cnt_x, x_cnt);
        check_eq({tag, "_blank_x"}, cnt_blank, 192);
        check_eq({tag, "_y_max"}, ymax, y_max);
    endtask

    task automatic do_reset(input string tag);
        sys_rst = 1'b1;
        @(negedge clk);
        check_eq({tag, "_hsync"}, hsync, 1);
        check_eq({tag, "_vsync"}, vsync, 1);
        check_eq({tag, "_rgb_valid"}, rgb_valid, 0);
        check_eq({tag, "_rgb"}, rgb, 0);
        check_eq({tag, "_frame_start"}, frame_start, 0);
        check_eq({tag, "_line_start"}, line_start, 0);
        check_eq({tag, "_pix_req"}, pix_req, 1);
        check_eq({tag, "_pix_xy"}, {pix_y, pix_x}, 0);
        check_eq({tag, "_hsync2"}, hsync2, 0);
        check_eq({tag, "_vsync2"}, vsync2, 0);
        check_eq({tag, "_pix_xy2"}, {pix_y2, pix_x2}, 0);
        repeat (4) @(negedge clk);
        sys_rst = 1'b0;
        sp = 0; cur_mode = 0; next_mode = 0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
        hist[0] = stage_exp(0, 0);
        k = 0;
    endtask

    initial begin
        int found, hi_cnt, hi_first, v_hi, val2, fs2, req2, rgb2_nz;
        sys_rst = 1'b1;
        scale_mode = 2'd0;

        do_reset("rst_init");
        repeat (LAT) step();
        run_frame("f0_1x", -1, 2'd0, 15, 12, 11);
        run_frame("f1_1x_switch", 150, 2'd1, 15, 12, 11);
        run_frame("f2_2x", 100, 2'd2, 7, 24, 5);
        run_frame("f3_4x", 100, 2'd0, 3, 48, 2);

        repeat (100) step();
        do_reset("rst_mid");
        repeat (LAT) step();
        run_frame("f4_after_rst", -1, 2'd0, 15, 12, 11);

        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (line_start2 === 1'b1) found = 1;
        end
        check_eq("pol_line_start_seen", found, 1);
        hi_cnt = 0; hi_first = -1;
        for (int i = 0; i < HT2; i++) begin
            if (i > 0) @(negedge clk);
            if (hsync2 === 1'b1) begin
                hi_cnt++;
                if (hi_first < 0) hi_first = i;
            end
        end
        check_eq("pol_hsync_high_width", hi_cnt, 6);
        check_eq("pol_hsync_offset", hi_first, 22);

        v_hi = 0; val2 = 0; fs2 = 0; req2 = 0; rgb2_nz = 0;
        repeat (HT2 * VT2) begin
            @(negedge clk);
            if (vsync2 === 1'b1) v_hi++;
            if (rgb_valid2 === 1'b1) val2++;
            if (frame_start2 === 1'b1) fs2++;
            if (pix_req2 === 1'b1) req2++;
            if (rgb2 !== 16'h0000) rgb2_nz++;
        end
        check_eq("pol_vsync_high", v_hi, 32);
        check_eq("pol_valid_count", val2, 80);
        check_eq("pol_fs_count", fs2, 1);
        check_eq("pol_req_count", req2, 80);
        check_eq("pol_rgb_zero", rgb2_nz, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator with a pixel-fetch interface and integer upscaling. It replaces the fixed 640x480 controller. Porch, sync and polarity values are parameters. A run-time scale mode (1x/2x/4x) lets a 640x480, 320x240 or 160x120 frame source fill the full screen. The sync, valid and colour outputs are delay-matched to a pixel source with known read latency. It sits between the game/frame-buffer logic (pixel source) and the VGA DAC pins.

## Interface
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BACK, 48, horizontal back porch (cycles)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- PIX_W, 16, colour word width
- PIPE_LAT, 2, cycles from pix_req/pix_x/pix_y to valid pix_data (0..7)
- CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- vga_clk  in  1  pixel clock, all logic on rising edge
- sys_rst  in  1  reset, synchronous, active-high
- scale_mode  in  2  0 = 1x, 1 = 2x, 2 = 4x, 3 = treated as 1x
- pix_req  out  1  fetch strobe: current counter position is in the active area
- pix_x  out  CNT_W  scaled source X (Hcnt >> shift) when pix_req, else all-ones
- pix_y  out  CNT_W  scaled source Y (Vcnt >> shift) when pix_req, else all-ones
- pix_data  in  PIX_W  source colour, valid PIPE_LAT cycles after the matching pix_req
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- rgb_valid  out  1  registered active-area flag aligned to rgb
- rgb  out  PIX_W  registered colour; 0 when rgb_valid = 0
- frame_start  out  1  one-cycle pulse with output pixel (0,0)
- line_start  out  1  one-cycle pulse with the first output pixel of every active line

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Hcnt counts 0..H_TOTAL-1 and wraps to 0. Vcnt increments on the Hcnt wrap, counts 0..V_TOTAL-1 and wraps to 0.
- Active area (stage 0): Hcnt < H_DISPLAY and Vcnt < V_DISPLAY. pix_req equals this flag, combinationally from the counters.
- Sync (stage 0): the hsync condition is Hcnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]. The vsync condition is Vcnt in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]. The output level is POL when the condition holds, otherwise !POL.
- Scaling: shift = 0/1/2 for mode_q = 0/1/2 (3 gives 0). Each source pixel repeats 2^shift cycles horizontally and 2^shift lines vertically.
- mode_q is loaded from scale_mode only on the last cycle of a frame (Hcnt = H_TOTAL-1, Vcnt = V_TOTAL-1). A change of scale_mode mid-frame never alters the current frame.
- Delay line: the stage-0 active flag, sync conditions, frame-start flag (Hcnt = 0, Vcnt = 0) and line-start flag (Hcnt = 0, Vcnt < V_DISPLAY) pass through a PIPE_LAT-deep shift register. They are then registered together with pix_data into the outputs.
- rgb <= delayed_active ? pix_data : 0.

## Timing
- The outputs for the counter position at cycle t appear at cycle t+PIPE_LAT+1. This applies to hsync, vsync, rgb_valid, rgb, frame_start and line_start.
- pix_data is sampled at edge t+PIPE_LAT.
- pix_req, pix_x and pix_y have zero latency relative to the counters.
- Reset (sys_rst high at an edge) sets the following:
  - Hcnt = 0, Vcnt = 0, mode_q = 0.
  - All delay stages cleared (inactive).
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL, rgb_valid = 0, rgb = 0, frame_start = 0, line_start = 0.
- While sys_rst is high, pix_req = 1 and pix_x/pix_y = 0, since the counters sit at 0. Sinks must ignore pix_req during reset.
- The first post-reset frame starts at Hcnt = 0. frame_start fires PIPE_LAT+1 cycles after reset deasserts.
- Reset mid-line/mid-frame aborts immediately. No partial-frame flush.
- Frame period: H_TOTAL*V_TOTAL cycles (420000 at defaults). hsync period: H_TOTAL cycles.

## Test plan
- Reset: hold sys_rst 5 cycles mid-frame -> hsync = vsync = 1, rgb_valid = 0, rgb = 0 on the following cycle. frame_start occurs exactly PIPE_LAT+1 = 3 cycles after release.
- Default 1x frame: run 2 frames.
  - hsync low for 96 cycles of every 800.
  - vsync low for 1600 cycles starting 490*800 cycles after frame_start.
  - 307200 rgb_valid cycles per frame.
  - 480 line_start pulses per frame.
- Latency alignment, PIPE_LAT = 2: model pix_data as {pix_y[7:0], pix_x[7:0]} delayed 2 cycles -> rgb at output pixel (x, y) equals {y[7:0], x[7:0]}, with no off-by-one at x = 0 or x = 639.
- 4x mode: scale_mode = 2 before frame end -> the next frame has pix_x stepping 0..159 with each value held 4 cycles, pix_y 0..119 with each value held 4 lines, and pix_x = 3FF in blanking.
- Mode change mid-frame: switch scale_mode 0 -> 1 at Vcnt = 200 -> the rest of the frame stays at 1x, and the next frame shows pix_x 0..319 with each value held 2 cycles.
- Polarity/geometry parameters: HSYNC_POL = 1, VSYNC_POL = 1, H_DISPLAY = 320, H_FRONT = 8, H_SYNC = 48, H_BACK = 24 -> hsync is high for 48 cycles per 400-cycle line, starting 328 cycles after line_start.
